// File: rtl/rr_scan4.sv
// rr_scan4: round-robin sequencer that steers a 4:1 mux through s1/s2, captures
// the mux output and offers it downstream over valid/ready with a one-cycle grant.
module rr_scan4 #(
  parameter int WIDTH    = 4,
  parameter int START_CH = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  output logic             s1,
  output logic             s2,
  input  logic [WIDTH-1:0] mux_e,
  output logic [3:0]       gnt,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_ch,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Seeded one behind START_CH so the first search begins at START_CH.
  localparam logic [1:0] LAST_INIT = 2'((START_CH + 3) % 4);

  state_t           state_r;
  logic [1:0]       sel_r;
  logic [1:0]       last_ch_r;
  logic [3:0]       gnt_r;
  logic [WIDTH-1:0] data_r;
  logic [1:0]       ch_r;
  logic             valid_r;
  logic [3:0]       rot_s;
  logic [1:0]       offset_s;
  logic [1:0]       winner_s;

  function automatic logic [3:0] onehot4(input logic [1:0] ch);
    onehot4 = 4'b0001 << ch;
  endfunction

  // Rotate req so the channel after last_ch lands at bit 0, then priority-encode.
  always_comb begin
    rot_s    = req;
    offset_s = 2'd0;
    case (last_ch_r)
      2'd0:    rot_s = {req[0], req[3:1]};
      2'd1:    rot_s = {req[1:0], req[3:2]};
      2'd2:    rot_s = {req[2:0], req[3]};
      2'd3:    rot_s = req;
      default: rot_s = req;
    endcase
    if (rot_s[0]) begin
      offset_s = 2'd0;
    end else if (rot_s[1]) begin
      offset_s = 2'd1;
    end else if (rot_s[2]) begin
      offset_s = 2'd2;
    end else begin
      offset_s = 2'd3;
    end
    winner_s = last_ch_r + 2'd1 + offset_s;
  end

  // Sequencer: pick in IDLE, sample the settled mux in CAPTURE, hold until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      sel_r     <= 2'd0;
      last_ch_r <= LAST_INIT;
      gnt_r     <= 4'b0000;
      data_r    <= '0;
      ch_r      <= 2'd0;
      valid_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          gnt_r <= 4'b0000;
          if (req != 4'b0000) begin
            sel_r   <= winner_s;
            state_r <= CAPTURE;
          end else begin
            state_r <= IDLE;
          end
        end
        CAPTURE: begin
          data_r    <= mux_e;
          ch_r      <= sel_r;
          valid_r   <= 1'b1;
          gnt_r     <= onehot4(sel_r);
          last_ch_r <= sel_r;
          state_r   <= HOLD;
        end
        HOLD: begin
          gnt_r <= 4'b0000;
          if (valid_r && out_ready) begin
            valid_r <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          gnt_r   <= 4'b0000;
          valid_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign s1        = sel_r[0];
  assign s2        = sel_r[1];
  assign gnt       = gnt_r;
  assign out_data  = data_r;
  assign out_ch    = ch_r;
  assign out_valid = valid_r;

endmodule

// File: tb/tb_rr_scan4.sv
// Bench for rr_scan4: directed table and hand sequences with fixed sources, then
// randomized traffic checked cycle by cycle against a rule-level reference model.
module tb_rr_scan4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic         s1;
  logic         s2;
  logic [W-1:0] mux_e;
  logic [3:0]   gnt;
  logic [W-1:0] out_data;
  logic [1:0]   out_ch;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] src [4];
  int           checks = 0;
  int           errors = 0;

  typedef struct {
    logic [3:0]  req;
    logic        rdy;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl [15];

  // Reference state for the randomized phase.
  logic [1:0] m_last;
  logic [1:0] m_sel;
  logic [1:0] m_ch;
  logic [3:0] m_data;
  logic [3:0] m_gnt;
  logic       m_valid;
  logic       m_pend;

  always #5 clk = ~clk;

  // Behavioural Mux4.
  assign mux_e = src[{s2, s1}];

  rr_scan4 #(.WIDTH(W), .START_CH(0)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .s1(s1), .s2(s2), .mux_e(mux_e),
    .gnt(gnt), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  function automatic logic [12:0] obs();
    return {out_valid, out_ch, out_data, gnt, s2, s1};
  endfunction

  function automatic logic [12:0] ex(input logic v, input logic [1:0] ch,
                                     input logic [3:0] d, input logic [3:0] g,
                                     input logic [1:0] sel);
    return {v, ch, d, g, sel};
  endfunction

  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {valid,ch,data,gnt,s2s1}=%h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic rdy);
    @(negedge clk);
    req       = r;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = 4'h0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", obs(), 13'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic word(input logic [3:0] r0, input logic [3:0] r1,
                      input logic [1:0] ch, input logic [3:0] d);
    step(r0, 1'b1);
    chk("word_sel", 13'({out_valid, gnt, s2, s1}), 13'({1'b0, 4'h0, ch}));
    step(r1, 1'b1);
    chk("word_cap", obs(), ex(1'b1, ch, d, 4'b0001 << ch, ch));
    step(r1, 1'b1);
    chk("word_done", obs(), ex(1'b0, ch, d, 4'h0, ch));
  endtask

  // Spec-level round-robin: first requester after the last served one, wrapping.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (int'(last) + k) % 4;
      if (r[c]) return 2'(c);
    end
    return 2'd0;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic rdy);
    if (m_valid) begin
      m_gnt = 4'h0;
      if (rdy) m_valid = 1'b0;
    end else if (m_pend) begin
      m_data  = src[m_sel];
      m_ch    = m_sel;
      m_valid = 1'b1;
      m_gnt   = 4'b0001 << m_sel;
      m_last  = m_sel;
      m_pend  = 1'b0;
    end else if (r != 4'h0) begin
      m_sel  = rr_pick(r, m_last);
      m_pend = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    src[0] = 4'h0; src[1] = 4'h5; src[2] = 4'hA; src[3] = 4'hF;

    // All requests held: rotation 0,1,2,3,0 at one word per three cycles.
    tbl[0]  = '{4'hF, 1'b1, ex(1'b0, 2'd0, 4'h0, 4'h0, 2'd0)};
    tbl[1]  = '{4'hF, 1'b1, ex(1'b1, 2'd0, 4'h0, 4'h1, 2'd0)};
    tbl[2]  = '{4'hF, 1'b1, ex(1'b0, 2'd0, 4'h0, 4'h0, 2'd0)};
    tbl[3]  = '{4'hF, 1'b1, ex(1'b0, 2'd0, 4'h0, 4'h0, 2'd1)};
    tbl[4]  = '{4'hF, 1'b1, ex(1'b1, 2'd1, 4'h5, 4'h2, 2'd1)};
    tbl[5]  = '{4'hF, 1'b1, ex(1'b0, 2'd1, 4'h5, 4'h0, 2'd1)};
    tbl[6]  = '{4'hF, 1'b1, ex(1'b0, 2'd1, 4'h5, 4'h0, 2'd2)};
    tbl[7]  = '{4'hF, 1'b1, ex(1'b1, 2'd2, 4'hA, 4'h4, 2'd2)};
    tbl[8]  = '{4'hF, 1'b1, ex(1'b0, 2'd2, 4'hA, 4'h0, 2'd2)};
    tbl[9]  = '{4'hF, 1'b1, ex(1'b0, 2'd2, 4'hA, 4'h0, 2'd3)};
    tbl[10] = '{4'hF, 1'b1, ex(1'b1, 2'd3, 4'hF, 4'h8, 2'd3)};
    tbl[11] = '{4'hF, 1'b1, ex(1'b0, 2'd3, 4'hF, 4'h0, 2'd3)};
    tbl[12] = '{4'hF, 1'b1, ex(1'b0, 2'd3, 4'hF, 4'h0, 2'd0)};
    tbl[13] = '{4'hF, 1'b1, ex(1'b1, 2'd0, 4'h0, 4'h1, 2'd0)};
    tbl[14] = '{4'hF, 1'b1, ex(1'b0, 2'd0, 4'h0, 4'h0, 2'd0)};

    // Single request on a after reset.
    do_reset();
    word(4'h1, 4'h0, 2'd0, 4'h0);

    do_reset();
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].req, tbl[i].rdy);
      chk("table", obs(), tbl[i].exp);
    end

    // Serve d, then lone c, then c+d: d must win over c.
    word(4'h8, 4'h0, 2'd3, 4'hF);
    word(4'h4, 4'h0, 2'd2, 4'hA);
    word(4'hC, 4'hC, 2'd3, 4'hF);
    word(4'hC, 4'h0, 2'd2, 4'hA);

    // Backpressure: word held five cycles, grant pulses once.
    step(4'h2, 1'b0);
    chk("bp_sel", 13'({out_valid, gnt, s2, s1}), 13'({1'b0, 4'h0, 2'd1}));
    step(4'h0, 1'b0);
    chk("bp_cap", obs(), ex(1'b1, 2'd1, 4'h5, 4'h2, 2'd1));
    for (int i = 0; i < 4; i++) begin
      step(4'h0, 1'b0);
      chk("bp_hold", obs(), ex(1'b1, 2'd1, 4'h5, 4'h0, 2'd1));
    end
    step(4'h0, 1'b1);
    chk("bp_release", obs(), ex(1'b0, 2'd1, 4'h5, 4'h0, 2'd1));

    // Asynchronous reset in the middle of HOLD.
    step(4'h8, 1'b0);
    step(4'h0, 1'b0);
    step(4'h0, 1'b0);
    chk("pre_rst_hold", obs(), ex(1'b1, 2'd3, 4'hF, 4'h0, 2'd3));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", obs(), 13'd0);
    @(negedge clk);
    rst_n = 1'b1;
    word(4'h8, 4'h0, 2'd3, 4'hF);

    // Quiet period: nothing moves.
    for (int i = 0; i < 10; i++) begin
      step(4'h0, 1'b1);
      chk("quiet", obs(), ex(1'b0, 2'd3, 4'hF, 4'h0, 2'd3));
    end

    // Randomized traffic against the reference model.
    do_reset();
    m_last = 2'd3; m_sel = 2'd0; m_ch = 2'd0; m_data = 4'h0;
    m_gnt = 4'h0; m_valid = 1'b0; m_pend = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      chk("random", obs(), ex(m_valid, m_ch, m_data, m_gnt, m_sel));
      if ($urandom_range(0, 3) == 0) req = 4'h0;
      else req = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < 4; k++) src[k] = 4'($urandom_range(0, 15));
      model_step(req, out_ready);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
